// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-port synchronous SRAM.
//   sram_state_e : clear sequencer state (CLEAR, READY)
//   BYTE_W       : bits per byte-enable lane
//   merge_be()   : byte-lane merge of a new word over an old word
package sram_pkg;

   localparam int unsigned BYTE_W  = 8;
   // Widest word merge_be() handles; callers zero-extend and truncate around it.
   localparam int unsigned MERGE_W = 256;
   localparam int unsigned MERGE_B = MERGE_W / BYTE_W;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } sram_state_e;

   // Take new_w bytes where be is set, old_w bytes elsewhere.
   function automatic logic [MERGE_W-1:0] merge_be(input logic [MERGE_W-1:0] old_w,
                                                   input logic [MERGE_W-1:0] new_w,
                                                   input logic [MERGE_B-1:0] be);
      logic [MERGE_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MERGE_B); i++) begin
         if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks every entry once after reset or clear_req.
//   clk, rst_n  : clock, async active-low reset
//   clear_req   : request a new clear pass (honoured only in READY)
//   clear_we    : high while a clear write is issued this cycle
//   clear_addr  : entry being cleared this cycle
//   busy        : high while clearing
module sram_clear_seq
   import sram_pkg::*;
#(
   parameter  int unsigned DEPTH  = 32,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   output logic              clear_we,
   output logic [ADDR_W-1:0] clear_addr,
   output logic              busy
);

   sram_state_e       state;
   logic [ADDR_W-1:0] clear_ptr;

   // State, pointer and busy flag; pointer wraps to 0 on its own after DEPTH-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         clear_ptr <= '0;
         busy      <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               clear_ptr <= clear_ptr + ADDR_W'(1);
               if (clear_ptr == ADDR_W'(DEPTH - 1)) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               if (clear_req) begin
                  state     <= CLEAR;
                  clear_ptr <= '0;
                  busy      <= 1'b1;
               end
            end
            default: begin
               state     <= CLEAR;
               clear_ptr <= '0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

   assign clear_we   = (state == CLEAR);
   assign clear_addr = clear_ptr;

endmodule

// File: rtl/sync_sram_mp.sv
// DEPTH x DATA_W synchronous SRAM, one byte-enabled write port, NUM_RD read ports.
//   clk, rst_n                       : clock, async active-low reset
//   chip_enable, wr_en/addr/data/be  : normal write port
//   rd_en, rd_addr, rd_data          : packed read ports, 1-cycle registered data
//   init_en/we/addr/data             : loader port, overrides normal traffic
//   clear_req, busy                  : re-run clear, clearing in progress
//   wr_drop                          : pulse after a discarded normal write
module sync_sram_mp
   import sram_pkg::*;
#(
   parameter  int unsigned       DATA_W      = 32,
   parameter  int unsigned       DEPTH       = 32,
   localparam int unsigned       ADDR_W      = $clog2(DEPTH),
   parameter  int unsigned       NUM_RD      = 2,
   parameter  bit                WRITE_FIRST = 1'b1,
   parameter  logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       chip_enable,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [DATA_W/8-1:0]        wr_be,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic                       init_en,
   input  logic                       init_we,
   input  logic [ADDR_W-1:0]          init_addr,
   input  logic [DATA_W-1:0]          init_data,
   input  logic                       clear_req,
   output logic                       busy,
   output logic                       wr_drop
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clear_we;
   logic [ADDR_W-1:0] clear_addr;
   logic              norm_act_c;
   logic              wr_act_c;
   logic [DATA_W-1:0] merged_c;

   sram_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_req  (clear_req),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .busy       (busy)
   );

   // Normal ports act only in READY with no clear request and no init mode.
   assign norm_act_c = ~busy & ~clear_req & ~init_en & chip_enable;
   assign wr_act_c   = norm_act_c & wr_en;
   assign merged_c   = DATA_W'(merge_be(MERGE_W'(mem[wr_addr]), MERGE_W'(wr_data),
                                        MERGE_B'(wr_be)));

   // Array write port: clear, then loader, then normal write.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[clear_addr] <= CLEAR_VAL;
      end else if (!clear_req && init_en) begin
         if (init_we) mem[init_addr] <= init_data;
      end else if (wr_act_c) begin
         mem[wr_addr] <= merged_c;
      end
   end

   // A normal write arriving while clearing, on clear_req, or in init mode is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_drop <= 1'b0;
      else        wr_drop <= chip_enable & wr_en & (busy | clear_req | init_en);
   end

   for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
      logic [ADDR_W-1:0] addr_c;
      logic [DATA_W-1:0] rd_q;
      logic              bypass_c;

      assign addr_c   = rd_addr[p*ADDR_W +: ADDR_W];
      assign bypass_c = WRITE_FIRST && wr_act_c && (addr_c == wr_addr);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_q <= '0;
         end else if (norm_act_c && rd_en[p]) begin
            rd_q <= bypass_c ? merged_c : mem[addr_c];
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = rd_q;
   end

endmodule

// File: tb/tb_sync_sram_mp.sv
// Randomised + directed bench for sync_sram_mp; two instances (write-first and
// read-first) share stimulus, and a queue-based scoreboard checks both.
module tb_sync_sram_mp;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NUM_RD = 2;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam logic [DATA_W-1:0] CLR = 32'h0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n, chip_enable, wr_en, init_en, init_we, clear_req;
   logic [ADDR_W-1:0]        wr_addr, init_addr;
   logic [DATA_W-1:0]        wr_data, init_data;
   logic [BE_W-1:0]          wr_be;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data_wf, rd_data_rf;
   logic                     busy_wf, busy_rf, wr_drop_wf, wr_drop_rf;

   sync_sram_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD),
                  .WRITE_FIRST(1'b1), .CLEAR_VAL(CLR)) dut_wf (
      .clk(clk), .rst_n(rst_n), .chip_enable(chip_enable), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data_wf), .init_en(init_en), .init_we(init_we),
      .init_addr(init_addr), .init_data(init_data), .clear_req(clear_req),
      .busy(busy_wf), .wr_drop(wr_drop_wf));

   sync_sram_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD),
                  .WRITE_FIRST(1'b0), .CLEAR_VAL(CLR)) dut_rf (
      .clk(clk), .rst_n(rst_n), .chip_enable(chip_enable), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data_rf), .init_en(init_en), .init_we(init_we),
      .init_addr(init_addr), .init_data(init_data), .clear_req(clear_req),
      .busy(busy_rf), .wr_drop(wr_drop_rf));

   typedef struct packed {
      logic        busy;
      logic        drop;
      logic [63:0] rd_wf;
      logic [63:0] rd_rf;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state
   logic [DATA_W-1:0] m_mem   [DEPTH];
   logic [DATA_W-1:0] m_rd_wf [NUM_RD];
   logic [DATA_W-1:0] m_rd_rf [NUM_RD];
   bit                m_clearing;
   int                m_ptr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic clr_in();
      chip_enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en = '0; rd_addr = '0; init_en = 1'b0; init_we = 1'b0; init_addr = '0;
      init_data = '0; clear_req = 1'b0;
   endtask

   // Apply the current inputs to the model for the coming clock edge and queue the result.
   task automatic tick();
      exp_t              e;
      logic [DATA_W-1:0] neww;
      int                ra;
      e.drop = 1'b0;
      if (!rst_n) begin
         m_clearing = 1'b1;
         m_ptr      = 0;
         for (int p = 0; p < int'(NUM_RD); p++) begin
            m_rd_wf[p] = '0; m_rd_rf[p] = '0;
         end
      end else if (m_clearing) begin
         m_mem[m_ptr] = CLR;
         m_ptr++;
         if (m_ptr == int'(DEPTH)) begin
            m_clearing = 1'b0;
            m_ptr      = 0;
         end
         e.drop = chip_enable & wr_en;
      end else if (clear_req) begin
         e.drop     = chip_enable & wr_en;
         m_clearing = 1'b1;
         m_ptr      = 0;
      end else if (init_en) begin
         if (init_we) m_mem[init_addr] = init_data;
         e.drop = chip_enable & wr_en;
      end else if (chip_enable) begin
         neww = m_mem[wr_addr];
         for (int b = 0; b < int'(BE_W); b++)
            if (wr_be[b]) neww[b*8 +: 8] = wr_data[b*8 +: 8];
         for (int p = 0; p < int'(NUM_RD); p++) begin
            if (rd_en[p]) begin
               ra         = int'(rd_addr[p*ADDR_W +: ADDR_W]);
               m_rd_rf[p] = m_mem[ra];
               m_rd_wf[p] = (wr_en && ra == int'(wr_addr)) ? neww : m_mem[ra];
            end
         end
         if (wr_en) m_mem[wr_addr] = neww;
      end
      e.busy  = m_clearing;
      e.rd_wf = {m_rd_wf[1], m_rd_wf[0]};
      e.rd_rf = {m_rd_rf[1], m_rd_rf[0]};
      q.push_back(e);
   endtask

   task automatic nop();
      @(negedge clk); clr_in(); tick();
   endtask

   task automatic rd2(input int a0, input int a1, input logic [1:0] en);
      @(negedge clk); clr_in();
      chip_enable = 1'b1; rd_en = en;
      rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
      tick();
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be,
                     input logic [1:0] en, input int ra0);
      @(negedge clk); clr_in();
      chip_enable = 1'b1; wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; wr_be = be;
      rd_en = en; rd_addr = {ADDR_W'(ra0), ADDR_W'(ra0)};
      tick();
   endtask

   task automatic read_all();
      for (int a = 0; a < int'(DEPTH) / 2; a++) rd2(a, a + int'(DEPTH) / 2, 2'b11);
   endtask

   // Monitor: one expected record per clock edge, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("busy_wf", 64'(busy_wf), 64'(e.busy));
            chk("busy_rf", 64'(busy_rf), 64'(e.busy));
            chk("wr_drop_wf", 64'(wr_drop_wf), 64'(e.drop));
            chk("wr_drop_rf", 64'(wr_drop_rf), 64'(e.drop));
            chk("rd_data_wf", rd_data_wf, e.rd_wf);
            chk("rd_data_rf", rd_data_rf, e.rd_rf);
         end
      end
   end

   initial begin
      int r;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      for (int p = 0; p < int'(NUM_RD); p++) begin
         m_rd_wf[p] = '0; m_rd_rf[p] = '0;
      end
      m_clearing = 1'b1;
      m_ptr      = 0;
      rst_n      = 1'b0;
      clr_in();
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy_wf), 64'd1);
      chk("reset_drop", 64'(wr_drop_wf), 64'd0);
      chk("reset_rd_wf", rd_data_wf, 64'd0);
      chk("reset_rd_rf", rd_data_rf, 64'd0);

      // Release reset; a write during the clear pass must be dropped.
      @(negedge clk); rst_n = 1'b1; clr_in(); tick();
      wr(4, 32'h1111_1111, 4'hF, 2'b00, 0);
      repeat (int'(DEPTH) + 2) nop();
      read_all();

      // Partial byte write over a cleared entry.
      wr(5, 32'hDEAD_BEEF, 4'b0101, 2'b00, 0);
      rd2(5, 5, 2'b11);
      wr(6, 32'hFFFF_FFFF, 4'b0000, 2'b00, 0);
      rd2(6, 5, 2'b11);

      // Read-during-write, both modes.
      wr(3, 32'h1111_2222, 4'hF, 2'b00, 0);
      wr(3, 32'h1234_5678, 4'hF, 2'b01, 3);
      rd2(3, 3, 2'b11);
      wr(3, 32'hAABB_CCDD, 4'b0011, 2'b11, 3);

      // Both ports on one address, then port 1 holds.
      wr(9, 32'hA5A5_A5A5, 4'hF, 2'b00, 0);
      rd2(9, 9, 2'b11);
      wr(9, 32'h0F0F_0F0F, 4'hF, 2'b00, 0);
      rd2(9, 9, 2'b01);

      // Loader overrides a normal write to the same entry.
      @(negedge clk); clr_in();
      init_en = 1'b1; init_we = 1'b1; init_addr = 5'd7; init_data = 32'hCAFE_F00D;
      chip_enable = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1; wr_be = 4'hF;
      rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
      tick();
      rd2(7, 7, 2'b11);

      // Clear request with a write in the same cycle.
      @(negedge clk); clr_in();
      clear_req = 1'b1; chip_enable = 1'b1; wr_en = 1'b1; wr_addr = 5'd2;
      wr_data = 32'h5555_5555; wr_be = 4'hF;
      tick();
      repeat (int'(DEPTH) + 2) nop();
      read_all();

      // Reset in the middle of a clear pass.
      wr(10, 32'h7777_8888, 4'hF, 2'b00, 0);
      @(negedge clk); clr_in(); clear_req = 1'b1; tick();
      repeat (10) nop();
      @(negedge clk); clr_in(); rst_n = 1'b0; tick();
      @(negedge clk); clr_in(); rst_n = 1'b1; tick();
      repeat (int'(DEPTH) + 2) nop();
      read_all();

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         @(negedge clk); clr_in();
         r = int'($urandom_range(0, 99));
         clear_req   = (r < 2);
         init_en     = (r >= 2 && r < 10);
         init_we     = 1'($urandom);
         init_addr   = ADDR_W'($urandom_range(0, 7));
         init_data   = $urandom;
         chip_enable = ($urandom_range(0, 3) != 0);
         wr_en       = 1'($urandom);
         wr_addr     = ADDR_W'($urandom_range(0, 7));
         wr_data     = $urandom;
         wr_be       = BE_W'($urandom);
         rd_en       = NUM_RD'($urandom);
         rd_addr     = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
         tick();
      end
      repeat (int'(DEPTH) + 2) nop();
      read_all();

      @(negedge clk); clr_in();
      repeat (2) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sync_sram_mp.md
# sync_sram_mp

Parametrised successor to the team's single-port 32x32 synchronous SRAM: a DEPTH x DATA_W synchronous memory with one byte-enabled write port, NUM_RD independent read ports, and a selectable read-during-write mode. A built-in clear sequencer fills the array with CLEAR_VAL after reset or on request, so software never reads uninitialised state. An init/loader port sits alongside and takes priority over normal traffic. Used as the register file and small data scratchpad of the RISC-V core.

## Interface
- DATA_W, 32, word width; multiple of 8
- DEPTH, 32, number of entries; power of two, >= 2
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- NUM_RD, 2, read port count, 1..4
- WRITE_FIRST, 1, 1: a same-address read returns the newly written data; 0: returns the old data
- CLEAR_VAL, '0, value written to every entry by the clear sequencer
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- chip_enable  in  1  qualifies all normal-port activity
- wr_en  in  1  normal write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit i enables data bits [8i+7:8i]
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD x ADDR_W  read addresses, packed
- rd_data  out  NUM_RD x DATA_W  read data, registered
- init_en  in  1  init mode; blocks the normal ports
- init_we  in  1  init write strobe
- init_addr  in  ADDR_W  init address
- init_data  in  DATA_W  init data; always a full-word write
- clear_req  in  1  single-cycle request to re-run the clear sequence
- busy  out  1  high while clearing
- wr_drop  out  1  one-cycle pulse when a normal write is discarded

## Operation
- FSM states: CLEAR, READY. Reset enters CLEAR with clear_ptr = 0.
- CLEAR:
  - Each cycle writes CLEAR_VAL to memory[clear_ptr], then increments clear_ptr.
  - When clear_ptr = DEPTH-1 is written, go to READY. Clearing takes exactly DEPTH cycles.
  - All normal and init writes are discarded. A discarded normal write (chip_enable & wr_en) pulses wr_drop.
  - rd_data holds its value.
  - clear_req is ignored.
- READY, by priority:
  1. clear_req: go to CLEAR, clear_ptr = 0. Any write in that cycle is discarded; a discarded normal write pulses wr_drop.
  2. init_en:
     - If init_we, write memory[init_addr] <= init_data.
     - Normal ports are ignored and rd_data holds.
     - A normal write presented in this cycle pulses wr_drop.
  3. Otherwise, if chip_enable:
     - If wr_en, update only the bytes of memory[wr_addr] whose wr_be bit is set. wr_be = 0 is a legal no-op.
     - Each port p with rd_en[p] set loads rd_data[p] from memory[rd_addr[p]].
     - Ports with rd_en[p] clear hold their value.
- Read-during-write, for port p with rd_addr[p] = wr_addr and an active write:
  - WRITE_FIRST=1: rd_data[p] gets the merged word (new bytes where wr_be is set, old bytes elsewhere).
  - WRITE_FIRST=0: rd_data[p] gets the pre-write word.
- Multiple read ports on the same address all return the same word.
- The memory array has no reset. Its contents after reset are defined only by the clear sequence.

## Timing
- Reset values: rd_data = 0 on all ports, busy = 1, wr_drop = 0, state = CLEAR.
- Read latency is 1 cycle: address at edge N gives rd_data valid after edge N+1.
- Write is visible to a read issued the following cycle.
- busy is a registered output. It is 1 from reset/clear_req through the cycle in which entry DEPTH-1 is written, and 0 from the next cycle. The first normal access is accepted on the first cycle busy = 0.
- wr_drop is registered. It is high for the cycle after the discarded request.
- If rst_n is asserted mid-clear or mid-write, the FSM returns asynchronously to CLEAR with clear_ptr = 0. A partially written entry is re-cleared.
- clear_ptr wraps naturally at DEPTH-1; no terminal-count overflow is allowed into ADDR_W+1 bits.

## Structure
- Package sram_pkg:
  - sram_state_e enum (CLEAR, READY)
  - a BYTE_W = 8 constant
  - a function for byte-enable merging, merge_be(old, new, be)
- Sub-module sram_clear_seq: owns the FSM, clear_ptr and busy. It exports clear_we, clear_addr and busy to the array/port logic in sync_sram_mp.
- The array and the read ports are a generate loop over NUM_RD in the top module.

## Test plan
- Reset, then hold chip_enable=0 -> busy=1 for exactly 32 cycles, then 0; reading every address returns 0.
- Write addr 5 = 0xDEADBEEF with wr_be=4'b0101, the entry previously all 0 -> read returns 0x00AD00EF.
- WRITE_FIRST=1: write addr 3 = 0x12345678 with rd_addr[0]=3 in the same cycle -> rd_data[0]=0x12345678 next cycle. With WRITE_FIRST=0 -> previous contents.
- init_en=1, init_we=1, init_addr=7, init_data=0xCAFEF00D, with a normal write to 7 = 0x1 in the same cycle -> entry 7 = 0xCAFEF00D, wr_drop pulses, rd_data holds.
- Pulse clear_req in READY with entries written -> busy high for 32 cycles and all entries read back as CLEAR_VAL. Assert rst_n low at clear_ptr=10 -> busy stays high, and the sequence restarts from 0 and completes in 32 cycles.
- NUM_RD=2, both ports reading addr 9 = 0xA5A5A5A5 -> both rd_data equal 0xA5A5A5A5. Port 1 with rd_en low -> keeps its previous value.
